// File: rtl/buffer_fifo_pkg.sv
// Shared constants for the buffer FIFO controller and its pointer counters.
// The optional BUFFER_FIFO_ERR_FLAGS_EN build adds sticky overflow/underflow outputs.
package buffer_fifo_pkg;

    localparam int ADDR_W_DEFAULT = 6;
    localparam int DEPTH          = 64;
    localparam int DATA_W         = 24;

endpackage

// File: rtl/buffer_fifo_ptr.sv
// Wrapping address counter with synchronous reset and increment enable.
// One instance drives the write address and a second one drives the read address.
module buffer_fifo_ptr
    import buffer_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_r;

    // Pointer register; wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {ADDR_W{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/buffer_fifo_ctrl.sv
// Control block for a FIFO built around an external buffer memory: pointers, occupancy, flags.
// Define BUFFER_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs cleared only by rst.
module buffer_fifo_ctrl
    import buffer_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              memclk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic              wren,
    output logic              rden,
    output logic [ADDR_W-1:0] wrptr,
    output logic [ADDR_W-1:0] rdptr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              rdvalid
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

    logic            wren_s;
    logic            rden_s;
    logic [ADDR_W:0] count_next_s;
    logic [ADDR_W:0] count_r;
    logic            full_r;
    logic            empty_r;
    logic            rdvalid_r;

    // Accept requests against the registered flags; reset blocks both memory strobes.
    always_comb begin
        wren_s = 1'b0;
        rden_s = 1'b0;
        if (rst) begin
            wren_s = 1'b0;
            rden_s = 1'b0;
        end else begin
            wren_s = push && !full_r;
            rden_s = pop && !empty_r;
        end
    end

    // Occupancy after this edge; a simultaneous write and read cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({wren_s, rden_s})
            2'b10:   count_next_s = count_r + ONE_COUNT;
            2'b01:   count_next_s = count_r - ONE_COUNT;
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy, flags and read-data-valid, all registered together.
    always_ff @(posedge memclk) begin
        if (rst) begin
            count_r   <= {(ADDR_W+1){1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            rdvalid_r <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            full_r    <= (count_next_s == FULL_COUNT);
            empty_r   <= (count_next_s == {(ADDR_W+1){1'b0}});
            rdvalid_r <= rden_s;
        end
    end

    buffer_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (memclk),
        .rst (rst),
        .inc (wren_s),
        .ptr (wrptr)
    );

    buffer_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (memclk),
        .rst (rst),
        .inc (rden_s),
        .ptr (rdptr)
    );

`ifdef BUFFER_FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; a push into a full FIFO alongside a pop is not an overflow.
    always_ff @(posedge memclk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (push && full_r && !pop);
            underflow_r <= underflow_r | (pop && empty_r);
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

    assign wren    = wren_s;
    assign rden    = rden_s;
    assign count   = count_r;
    assign full    = full_r;
    assign empty   = empty_r;
    assign rdvalid = rdvalid_r;

endmodule

// File: tb/tb_buffer_fifo_ctrl.sv
// Directed bench for buffer_fifo_ctrl: occupancy model checked every cycle plus literal checkpoints.
// Error-flag checks are compiled in with BUFFER_FIFO_ERR_FLAGS_EN.
module tb_buffer_fifo_ctrl;

    localparam int AW = 6;
    localparam int DEP = 64;

    logic          memclk = 1'b0;
    logic          rst    = 1'b1;
    logic          push   = 1'b0;
    logic          pop    = 1'b0;
    logic          wren;
    logic          rden;
    logic [AW-1:0] wrptr;
    logic [AW-1:0] rdptr;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          rdvalid;
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: occupancy and pointer positions as plain integers.
    int m_count   = 0;
    int m_wr      = 0;
    int m_rd      = 0;
    int m_rdvalid = 0;
    int m_ovf     = 0;
    int m_udf     = 0;

    buffer_fifo_ctrl #(.ADDR_W(AW)) dut (
        .memclk  (memclk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wren    (wren),
        .rden    (rden),
        .wrptr   (wrptr),
        .rdptr   (rdptr),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .rdvalid (rdvalid)
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 memclk = ~memclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: a request is honoured only if there is room / data, reset wins.
    always @(posedge memclk) begin
        int w;
        int r;
        if (rst) begin
            m_count   <= 0;
            m_wr      <= 0;
            m_rd      <= 0;
            m_rdvalid <= 0;
            m_ovf     <= 0;
            m_udf     <= 0;
        end else begin
            w = (push && m_count < DEP) ? 1 : 0;
            r = (pop && m_count > 0) ? 1 : 0;
            m_count   <= m_count + w - r;
            m_wr      <= (m_wr + w) % DEP;
            m_rd      <= (m_rd + r) % DEP;
            m_rdvalid <= r;
            if (push && m_count == DEP && !pop) m_ovf <= 1;
            if (pop && m_count == 0) m_udf <= 1;
        end
    end

    // Compare process: every cycle, mid-period, all outputs against the model.
    always @(negedge memclk) begin
        if (chk_en) begin
            check("wren",    int'(wren),    (push && !rst && m_count != DEP) ? 1 : 0);
            check("rden",    int'(rden),    (pop && !rst && m_count != 0) ? 1 : 0);
            check("count",   int'(count),   m_count);
            check("full",    int'(full),    (m_count == DEP) ? 1 : 0);
            check("empty",   int'(empty),   (m_count == 0) ? 1 : 0);
            check("wrptr",   int'(wrptr),   m_wr);
            check("rdptr",   int'(rdptr),   m_rd);
            check("rdvalid", int'(rdvalid), m_rdvalid);
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
            check("overflow",  int'(overflow),  m_ovf);
            check("underflow", int'(underflow), m_udf);
`endif
        end
    end

    // Apply inputs just after an edge and land where outputs have settled.
    task automatic drive(input logic p, input logic q, input logic r);
        @(posedge memclk);
        #1;
        push = p;
        pop  = q;
        rst  = r;
        #2;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full",  int'(full),  0);
        check("rst_wren",  int'(wren),  0);
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        check("rst_wrptr", int'(wrptr), 0);
        check("rst_rdvalid", int'(rdvalid), 0);

        // Fill: write address walks 0..63.
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check("fill_wrptr", int'(wrptr), i);
            check("fill_wren",  int'(wren),  1);
        end
        drive(1'b1, 1'b0, 1'b0);
        check("full_count", int'(count), 64);
        check("full_flag",  int'(full),  1);
        check("full_wrap",  int'(wrptr), 0);
        check("push65_wren", int'(wren), 0);

        // Push and pop while full: only the pop goes through.
        drive(1'b1, 1'b1, 1'b0);
        check("fpp_rden", int'(rden), 1);
        check("fpp_wren", int'(wren), 0);
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
        check("ovf_set", int'(overflow), 1);
`endif
        drive(1'b0, 1'b0, 1'b0);
        check("fpp_count", int'(count), 63);
        check("fpp_full",  int'(full),  0);
        drive(1'b1, 1'b0, 1'b0);

        // Drain: read address walks 1..63,0 after the earlier read.
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            check("drain_rdptr", int'(rdptr), (i + 1) % 64);
            check("drain_rden",  int'(rden),  1);
            check("drain_rdvalid", int'(rdvalid), (i == 0) ? 0 : 1);
        end
        drive(1'b0, 1'b0, 1'b0);
        check("drain_last_rdvalid", int'(rdvalid), 1);
        check("drain_empty", int'(empty), 1);
        check("drain_count", int'(count), 0);
        check("drain_rdptr_end", int'(rdptr), 1);
        drive(1'b0, 1'b1, 1'b0);
        check("udf_rden", int'(rden), 0);
        check("udf_rdvalid", int'(rdvalid), 0);

        // Push and pop while empty: no fall-through.
        drive(1'b1, 1'b1, 1'b0);
        check("epp_wren", int'(wren), 1);
        check("epp_rden", int'(rden), 0);
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
        check("udf_set", int'(underflow), 1);
`endif
        drive(1'b1, 1'b1, 1'b0);
        check("epp2_count", int'(count), 1);
        check("epp2_wren",  int'(wren),  1);
        check("epp2_rden",  int'(rden),  1);
        drive(1'b0, 1'b0, 1'b0);
        check("epp3_count", int'(count), 1);

        // Build to 10 entries then reset with a push pending.
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check("rst10_count", int'(count), 10);
        check("rst10_wren",  int'(wren),  0);
        drive(1'b0, 1'b0, 1'b0);
        check("post_rst_count", int'(count), 0);
        check("post_rst_empty", int'(empty), 1);
        check("post_rst_wrptr", int'(wrptr), 0);
        check("post_rst_rdptr", int'(rdptr), 0);
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
        check("post_rst_ovf", int'(overflow),  0);
        check("post_rst_udf", int'(underflow), 0);
`endif
        drive(1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffer_fifo_ctrl.md
BUFFER_FIFO_CTRL -- requirements
Module: buffer_fifo_ctrl

Interface
REQ-001 Parameter: ADDR_W, 6, pointer width; FIFO depth = 2**ADDR_W = 64 entries.
REQ-002 Port: memclk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: push  input  1  write request from producer.
REQ-005 Port: pop  input  1  read request from consumer.
REQ-006 Port: wren  output  1  write enable to buffer memory (combinational).
REQ-007 Port: rden  output  1  read enable to buffer memory (combinational).
REQ-008 Port: wrptr  output  ADDR_W  write address to buffer memory (registered).
REQ-009 Port: rdptr  output  ADDR_W  read address to buffer memory (registered).
REQ-010 Port: full  output  1  no free entry (registered).
REQ-011 Port: empty  output  1  no stored entry (registered).
REQ-012 Port: count  output  ADDR_W+1  stored entries, 0..64 (registered).
REQ-013 Port: rdvalid  output  1  memory rddata valid this cycle (registered).

Function
REQ-014 wren SHALL equal push && !full; rden SHALL equal pop && !empty, same cycle.
REQ-015 On wren, wrptr SHALL increment by 1 at next edge, modulo 64 (63 -> 0).
REQ-016 On rden, rdptr SHALL increment by 1 at next edge, modulo 64.
REQ-017 count SHALL: +1 on wren only; -1 on rden only; unchanged on both or neither.
REQ-018 full SHALL be 1 iff next count == 64; empty SHALL be 1 iff next count == 0; both registered with count.
REQ-019 Push while full with pop: pop accepted, push rejected; count 64 -> 63.
REQ-020 Push while empty with pop: push accepted, pop rejected (no fall-through); count 0 -> 1.
REQ-021 Push with pop, neither full nor empty: both accepted; count unchanged; both pointers advance.
REQ-022 rdvalid SHALL be rden delayed one memclk cycle, matching the memory's one-cycle registered read latency.
REQ-023 Rejected push/pop SHALL leave all state unchanged (except REQ-029 flags).

Reset
REQ-024 While rst=1 at edge: wrptr=0, rdptr=0, count=0, empty=1, full=0, rdvalid=0, error flags=0.
REQ-025 rst SHALL take priority over push/pop in the same cycle; entries in flight are discarded, memory contents untouched.
REQ-026 wren and rden SHALL be 0 whenever rst=1.

Configuration
REQ-027 Macro BUFFER_FIFO_ERR_FLAGS_EN compiles in sticky error reporting.
REQ-028 With macro: extra outputs overflow (1) and underflow (1), registered, cleared only by rst.
REQ-029 With macro: overflow sets on push && full && !pop; underflow sets on pop && empty.
REQ-030 Without macro: ports absent; rejected requests silently dropped.

Structure
REQ-031 Shared package buffer_fifo_pkg SHALL hold ADDR_W default, DEPTH = 64, DATA_W = 24.
REQ-032 Sub-module buffer_fifo_ptr (ADDR_W-bit wrapping counter with sync reset and increment enable) SHALL be instantiated twice, once per pointer.
REQ-033 Controller plus memory SHALL form the FIFO; memory data paths do not pass through this block.

Verification
REQ-034 Reset, then 64 pushes with no pops -> wrptr 0..63 then 0, count=64, full=1 after the 64th, 65th push gives wren=0.
REQ-035 From full, 64 pops -> rdptr wraps to 0, rdvalid one cycle after each rden, empty=1, count=0.
REQ-036 Empty, push&pop same cycle -> wren=1, rden=0, count=1; next cycle push&pop -> both 1, count stays 1.
REQ-037 Full, push&pop -> rden=1, wren=0, count=63, full=0.
REQ-038 rst asserted at count=10 with push=1 -> next cycle count=0, empty=1, pointers 0, wren=0 during rst.
REQ-039 With BUFFER_FIFO_ERR_FLAGS_EN: pop when empty -> underflow=1 and held; push when full (no pop) -> overflow=1; both clear only on rst.
